pkt_rx_checker: RTL and testbench
=================================

// Module: pkt_rx_checker
// PURPOSE
//  Ingress stage between the router local output port and the network input of the PE-side
//  packing/unpacking converter. Buffers incoming flits in a small FIFO and forwards them
//  unchanged. Checks HEAD/BODY/TAIL framing, latches the source id carried in each HEAD and
//  counts good packets and framing errors. Monitor only: flits are never dropped or altered.
// PARAMETERS
//  DEPTH      4   FIFO depth in flits; power of 2, >=2
//  DEPTH_LOG  2   log2(DEPTH)
//  CNT_W      16  width of pkt_cnt_o / err_cnt_o
// PORTS
//  clk          in   1        clock, all logic on rising edge
//  rstn         in   1        reset, synchronous, active-low
//  valid_i      in   1        flit valid from router
//  data_i       in   `DW      flit from router; type in [`DW-1:`DW-2]
//  ready_o      out  1        accept from router
//  valid_o      out  1        flit valid to converter network input
//  data_o       out  `DW      flit to converter, bit-identical to the accepted flit
//  ready_i      in   1        converter accepts
//  src_id_o     out  10       sid from the low 10 bits of the last accepted HEAD
//  pkt_done_o   out  1        1-cycle pulse: well-formed packet completed
//  err_o        out  1        1-cycle pulse: framing error detected
//  pkt_cnt_o    out  CNT_W    good-packet count, saturating
//  err_cnt_o    out  CNT_W    error count, saturating
// BEHAVIOUR
//  Reset (rstn=0 at a clk edge): FIFO empty, rd/wr ptrs and occupancy 0, FSM=WAIT_HEAD,
//   body_cnt=0, all outputs 0 except ready_o=1 from the first cycle after reset.
//  FIFO: push = valid_i & ready_o; pop = valid_o & ready_i. ready_o = (occupancy != DEPTH),
//   from registered occupancy only (no combinational path from ready_i).
//   valid_o = (occupancy != 0); data_o = entry at rd ptr (first-word fall-through).
//   Latency: flit pushed at edge N visible on data_o after edge N, i.e. earliest pop cycle N+1.
//   No bypass. Push+pop same cycle: occupancy unchanged. Full: no push even if pop occurs
//   the same cycle. Pointers wrap modulo DEPTH. Order strictly preserved.
//  Framing FSM advances on every push, inspecting data_i[`DW-1:`DW-2]:
//   WAIT_HEAD: `HEAD -> latch sid, body_cnt=0, go IN_PKT.
//              `BODY or `TAIL -> err (orphan), stay.
//   IN_PKT:    `BODY -> if body_cnt == `PKT_LEN-2 then err (overlong), hold body_cnt;
//                       else body_cnt+1. Stay.
//              `TAIL -> if body_cnt == `PKT_LEN-2 then pkt_done, else err (short);
//                       go WAIT_HEAD.
//              `HEAD -> err (truncated); latch new sid, body_cnt=0, stay IN_PKT.
//   Any other type code in any state -> err, state unchanged.
//  body_cnt width `PKT_LEN_LOG. pkt_done_o/err_o assert the cycle after the offending push,
//   at most one per push; an overlong packet flags once per extra BODY, and its TAIL is
//   then also flagged short=no (counts good only if body_cnt==`PKT_LEN-2, which it is).
//   Design intent: overlong packet -> one err per extra BODY plus pkt_done at TAIL.
//  Counters: +1 per pulse; stick at all-ones. src_id_o holds until the next HEAD.
//  Reset mid-packet: state discarded; remaining BODY/TAIL flits flag orphan errors but
//   are still buffered and forwarded.
// TESTING (bench builds with `PKT_LEN=8)
//  T1 HEAD(sid=0x155), 6 BODY, TAIL back-to-back, ready_i=1 -> 8 flits out unchanged, in order,
//   first on cycle after first push; pkt_done_o once; pkt_cnt_o=1; src_id_o=0x155; err_cnt_o=0.
//  T2 ready_i=0, stream 6 flits -> exactly 4 accepted, ready_o=0 after 4th; raise ready_i with
//   valid_i held -> remaining flits accepted, order preserved, wrap-around correct.
//  T3 HEAD, 3 BODY, TAIL -> err_o once at TAIL, err_cnt_o=1, pkt_cnt_o=0, FSM back to WAIT_HEAD.
//  T4 BODY then TAIL with no HEAD -> 2 err pulses, err_cnt_o=2; both flits still forwarded.
//  T5 HEAD(sid=3), 2 BODY, HEAD(sid=7), 6 BODY, TAIL -> err_cnt_o=1, pkt_cnt_o=1, src_id_o=7.
//  T6 rstn=0 for 1 cycle after 3 flits of a packet, then 5 BODY + TAIL -> FIFO empty, valid_o=0
//   after reset; 6 orphan errors; counters cleared by reset then err_cnt_o=6.

Source files
------------

// File: rtl/pkt_rx_checker.sv
// Ingress buffer in front of the PE packing/unpacking converter. Flits pass through a small
// first-word-fall-through FIFO unchanged while a monitor checks HEAD/BODY/TAIL framing.
`ifndef DW
`define DW 32
`endif
`ifndef PKT_LEN
`define PKT_LEN 8
`endif
`ifndef PKT_LEN_LOG
`define PKT_LEN_LOG 3
`endif
`ifndef HEAD
`define HEAD 2'b00
`endif
`ifndef BODY
`define BODY 2'b01
`endif
`ifndef TAIL
`define TAIL 2'b10
`endif

module pkt_rx_checker #(
   parameter int DEPTH     = 4,
   parameter int DEPTH_LOG = 2,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             valid_i,
   input  logic [`DW-1:0]   data_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [`DW-1:0]   data_o,
   input  logic             ready_i,
   output logic [9:0]       src_id_o,
   output logic             pkt_done_o,
   output logic             err_o,
   output logic [CNT_W-1:0] pkt_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   typedef enum logic {WAIT_HEAD, IN_PKT} state_t;

   localparam logic [`PKT_LEN_LOG-1:0] LAST_BODY = `PKT_LEN_LOG'(`PKT_LEN - 2);

   logic [`DW-1:0]       mem_reg [DEPTH];
   logic [DEPTH-1:0]     wr_en;
   logic [DEPTH_LOG-1:0] rd_ptr_reg, wr_ptr_reg;
   logic [DEPTH_LOG:0]   occ_reg, occ_next;
   logic                 push, pop;

   state_t               state_reg, state_next;
   logic [`PKT_LEN_LOG-1:0] body_cnt_reg, body_cnt_next;
   logic [9:0]           sid_reg, sid_next;
   logic                 done_reg, done_next;
   logic                 err_reg, err_next;
   logic [CNT_W-1:0]     pkt_cnt_reg, pkt_cnt_next;
   logic [CNT_W-1:0]     err_cnt_reg, err_cnt_next;
   logic [1:0]           flit_type;

   // Flow control depends only on registered occupancy, never on ready_i.
   assign ready_o = (occ_reg != (DEPTH_LOG + 1)'(DEPTH));
   assign valid_o = (occ_reg != '0);
   assign data_o  = mem_reg[rd_ptr_reg];
   assign push    = valid_i & ready_o;
   assign pop     = valid_o & ready_i;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
         assign wr_en[gi] = push && (wr_ptr_reg == DEPTH_LOG'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (!rstn)
            mem_reg[i] <= '0;
         else if (wr_en[i])
            mem_reg[i] <= data_i;
      end
   end

   always_comb begin
      occ_next = occ_reg;
      case ({push, pop})
         2'b10:   occ_next = occ_reg + 1'b1;
         2'b01:   occ_next = occ_reg - 1'b1;
         default: occ_next = occ_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         occ_reg    <= '0;
      end else begin
         occ_reg <= occ_next;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   assign flit_type = data_i[`DW-1:`DW-2];

   always_comb begin
      state_next    = state_reg;
      body_cnt_next = body_cnt_reg;
      sid_next      = sid_reg;
      done_next     = 1'b0;
      err_next      = 1'b0;
      if (push) begin
         case (state_reg)
            WAIT_HEAD: begin
               if (flit_type == `HEAD) begin
                  sid_next      = data_i[9:0];
                  body_cnt_next = '0;
                  state_next    = IN_PKT;
               end else begin
                  err_next = 1'b1;
               end
            end
            IN_PKT: begin
               case (flit_type)
                  `BODY: begin
                     // An overlong packet flags every extra BODY but keeps the count pinned.
                     if (body_cnt_reg == LAST_BODY)
                        err_next = 1'b1;
                     else
                        body_cnt_next = body_cnt_reg + 1'b1;
                  end
                  `TAIL: begin
                     if (body_cnt_reg == LAST_BODY)
                        done_next = 1'b1;
                     else
                        err_next = 1'b1;
                     state_next = WAIT_HEAD;
                  end
                  `HEAD: begin
                     err_next      = 1'b1;
                     sid_next      = data_i[9:0];
                     body_cnt_next = '0;
                  end
                  default: err_next = 1'b1;
               endcase
            end
            default: state_next = WAIT_HEAD;
         endcase
      end
   end

   always_comb begin
      pkt_cnt_next = pkt_cnt_reg;
      err_cnt_next = err_cnt_reg;
      if (done_next && (pkt_cnt_reg != '1))
         pkt_cnt_next = pkt_cnt_reg + 1'b1;
      if (err_next && (err_cnt_reg != '1))
         err_cnt_next = err_cnt_reg + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg    <= WAIT_HEAD;
         body_cnt_reg <= '0;
         sid_reg      <= '0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         pkt_cnt_reg  <= '0;
         err_cnt_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         body_cnt_reg <= body_cnt_next;
         sid_reg      <= sid_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
         pkt_cnt_reg  <= pkt_cnt_next;
         err_cnt_reg  <= err_cnt_next;
      end
   end

   assign src_id_o   = sid_reg;
   assign pkt_done_o = done_reg;
   assign err_o      = err_reg;
   assign pkt_cnt_o  = pkt_cnt_reg;
   assign err_cnt_o  = err_cnt_reg;

endmodule

// File: tb/tb_pkt_rx_checker.sv
// Directed bench for pkt_rx_checker: vector tables for cycle-exact behaviour plus
// hand-written sequences with an ordering scoreboard for back-pressure and reset cases.
`ifndef DW
`define DW 32
`endif
`ifndef PKT_LEN
`define PKT_LEN 8
`endif
`ifndef PKT_LEN_LOG
`define PKT_LEN_LOG 3
`endif
`ifndef HEAD
`define HEAD 2'b00
`endif
`ifndef BODY
`define BODY 2'b01
`endif
`ifndef TAIL
`define TAIL 2'b10
`endif

module tb_pkt_rx_checker;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rstn;
   logic             valid_i;
   logic [`DW-1:0]   data_i;
   logic             ready_o;
   logic             valid_o;
   logic [`DW-1:0]   data_o;
   logic             ready_i;
   logic [9:0]       src_id_o;
   logic             pkt_done_o;
   logic             err_o;
   logic [CNT_W-1:0] pkt_cnt_o;
   logic [CNT_W-1:0] err_cnt_o;

   pkt_rx_checker #(.DEPTH(4), .DEPTH_LOG(2), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .valid_i   (valid_i),
      .data_i    (data_i),
      .ready_o   (ready_o),
      .valid_o   (valid_o),
      .data_o    (data_o),
      .ready_i   (ready_i),
      .src_id_o  (src_id_o),
      .pkt_done_o(pkt_done_o),
      .err_o     (err_o),
      .pkt_cnt_o (pkt_cnt_o),
      .err_cnt_o (err_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic           v;
      logic [`DW-1:0] d;
      logic           r;
      logic           e_ready;
      logic           e_valid;
      logic [`DW-1:0] e_data;
      logic           e_done;
      logic           e_err;
   } vec_t;

   vec_t           tbl[$];
   logic [`DW-1:0] exp_q[$];
   int             n_vec = 0;
   int             n_bad = 0;
   int             n_done = 0;
   int             n_err = 0;
   int             n_pop = 0;

   function automatic logic [`DW-1:0] mkf(input logic [1:0] t, input logic [29:0] tag);
      return {t, tag};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic v, input logic [`DW-1:0] d, input logic r, input logic er,
                      input logic ev, input logic [`DW-1:0] ed, input logic edn, input logic eer);
      vec_t x;
      x.v = v; x.d = d; x.r = r; x.e_ready = er; x.e_valid = ev;
      x.e_data = ed; x.e_done = edn; x.e_err = eer;
      tbl.push_back(x);
   endtask

   // Inputs change 1 ns after the rising edge; outputs are judged at the falling edge.
   task automatic run_tbl(input string name);
      foreach (tbl[i]) begin
         valid_i = tbl[i].v; data_i = tbl[i].d; ready_i = tbl[i].r;
         @(negedge clk);
         chk({name, "_ready"}, 32'(ready_o), 32'(tbl[i].e_ready));
         chk({name, "_valid"}, 32'(valid_o), 32'(tbl[i].e_valid));
         if (tbl[i].e_valid)
            chk({name, "_data"}, data_o, tbl[i].e_data);
         chk({name, "_done"}, 32'(pkt_done_o), 32'(tbl[i].e_done));
         chk({name, "_err"}, 32'(err_o), 32'(tbl[i].e_err));
         $display("%s vec %0d: v=%0b d=%h r=%0b -> rdy=%0b vld=%0b do=%h done=%0b err=%0b",
                  name, i, tbl[i].v, tbl[i].d, tbl[i].r, ready_o, valid_o, data_o,
                  pkt_done_o, err_o);
         @(posedge clk); #1;
      end
      tbl.delete();
   endtask

   // One cycle with scoreboarded pushes/pops; acc returns the ready_o seen this cycle.
   task automatic cyc(input logic v, input logic [`DW-1:0] d, input logic r, output logic acc);
      valid_i = v; data_i = d; ready_i = r;
      @(negedge clk);
      acc = ready_o;
      if (valid_o && ready_i) begin
         n_pop++;
         if (exp_q.size() == 0)
            chk("pop_unexpected", 32'(valid_o), 32'd0);
         else
            chk("pop_order", data_o, exp_q.pop_front());
      end
      if (valid_i && ready_o)
         exp_q.push_back(data_i);
      n_done += int'(pkt_done_o);
      n_err  += int'(err_o);
      $display("cyc: v=%0b d=%h r=%0b -> rdy=%0b vld=%0b do=%h done=%0b err=%0b",
               v, d, r, ready_o, valid_o, data_o, pkt_done_o, err_o);
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [`DW-1:0] d);
      logic acc;
      int   k = 0;
      acc = 1'b0;
      while (!acc && k < 20) begin
         cyc(1'b1, d, 1'b1, acc);
         k++;
      end
      if (!acc)
         chk("send_timeout", 32'(acc), 32'd1);
   endtask

   task automatic drain();
      logic acc;
      int   k = 0;
      while ((exp_q.size() != 0) && k < 20) begin
         cyc(1'b0, '0, 1'b1, acc);
         k++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      cyc(1'b0, '0, 1'b1, acc);
      cyc(1'b0, '0, 1'b1, acc);
   endtask

   task automatic do_reset();
      rstn = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rstn = 1'b1;
      exp_q.delete();
      n_done = 0; n_err = 0; n_pop = 0;
   endtask

   logic [`DW-1:0] f[8];
   logic           acc;
   int             idx;
   int             k;

   initial begin
      do_reset();

      // Reset state
      @(negedge clk);
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_data", data_o, 32'd0);
      chk("rst_sid", 32'(src_id_o), 32'd0);
      chk("rst_done", 32'(pkt_done_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_pktcnt", 32'(pkt_cnt_o), 32'd0);
      chk("rst_errcnt", 32'(err_cnt_o), 32'd0);
      @(posedge clk); #1;

      // T1: well-formed packet streamed back-to-back
      f[0] = mkf(`HEAD, 30'h0100155);
      for (int i = 1; i < 7; i++) f[i] = mkf(`BODY, 30'h0200000 + 30'(i));
      f[7] = mkf(`TAIL, 30'h0300000);
      for (int i = 0; i < 8; i++)
         add(1'b1, f[i], 1'b1, 1'b1, i > 0, (i > 0) ? f[(i > 0) ? i - 1 : 0] : '0, 1'b0, 1'b0);
      add(1'b0, '0, 1'b1, 1'b1, 1'b1, f[7], 1'b1, 1'b0);
      add(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      run_tbl("t1");
      chk("t1_pktcnt", 32'(pkt_cnt_o), 32'd1);
      chk("t1_errcnt", 32'(err_cnt_o), 32'd0);
      chk("t1_sid", 32'(src_id_o), 32'h155);

      // T2: back-pressure fills the FIFO, then drains with wrap-around
      do_reset();
      for (int i = 0; i < 6; i++) f[i] = mkf(`BODY, 30'h0A00000 + 30'(i));
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         cyc(1'b1, f[idx], 1'b0, acc);
         chk("t2_ready", 32'(acc), 32'(c < 4));
         if (acc) idx++;
      end
      chk("t2_accepted", 32'(idx), 32'd4);
      cyc(1'b1, f[idx], 1'b1, acc);
      chk("t2_full_no_push", 32'(acc), 32'd0);
      k = 0;
      while (idx < 6 && k < 20) begin
         cyc(1'b1, f[idx], 1'b1, acc);
         if (acc) idx++;
         k++;
      end
      chk("t2_all_in", 32'(idx), 32'd6);
      drain();
      chk("t2_pops", 32'(n_pop), 32'd6);

      // T3: short packet
      do_reset();
      f[0] = mkf(`HEAD, 30'h00000AA);
      for (int i = 1; i < 4; i++) f[i] = mkf(`BODY, 30'h0B00000 + 30'(i));
      f[4] = mkf(`TAIL, 30'h0C00000);
      for (int i = 0; i < 5; i++)
         add(1'b1, f[i], 1'b1, 1'b1, i > 0, (i > 0) ? f[(i > 0) ? i - 1 : 0] : '0, 1'b0, 1'b0);
      add(1'b0, '0, 1'b1, 1'b1, 1'b1, f[4], 1'b0, 1'b1);
      add(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      run_tbl("t3");
      chk("t3_errcnt", 32'(err_cnt_o), 32'd1);
      chk("t3_pktcnt", 32'(pkt_cnt_o), 32'd0);
      // A clean packet right after proves the FSM returned to WAIT_HEAD.
      send(mkf(`HEAD, 30'h0000011));
      for (int i = 0; i < 6; i++) send(mkf(`BODY, 30'(i)));
      send(mkf(`TAIL, 30'h0));
      drain();
      chk("t3_after_errcnt", 32'(err_cnt_o), 32'd1);
      chk("t3_after_pktcnt", 32'(pkt_cnt_o), 32'd1);

      // T4: orphan BODY and TAIL
      do_reset();
      f[0] = mkf(`BODY, 30'h0D00001);
      f[1] = mkf(`TAIL, 30'h0D00002);
      add(1'b1, f[0], 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      add(1'b1, f[1], 1'b1, 1'b1, 1'b1, f[0], 1'b0, 1'b1);
      add(1'b0, '0, 1'b1, 1'b1, 1'b1, f[1], 1'b0, 1'b1);
      add(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      run_tbl("t4");
      chk("t4_errcnt", 32'(err_cnt_o), 32'd2);
      chk("t4_pktcnt", 32'(pkt_cnt_o), 32'd0);

      // T5: truncated packet followed by a complete one
      do_reset();
      send(mkf(`HEAD, 30'h0000003));
      send(mkf(`BODY, 30'h1)); send(mkf(`BODY, 30'h2));
      send(mkf(`HEAD, 30'h0000007));
      for (int i = 0; i < 6; i++) send(mkf(`BODY, 30'h10 + 30'(i)));
      send(mkf(`TAIL, 30'h0));
      drain();
      chk("t5_errcnt", 32'(err_cnt_o), 32'd1);
      chk("t5_pktcnt", 32'(pkt_cnt_o), 32'd1);
      chk("t5_sid", 32'(src_id_o), 32'd7);
      chk("t5_err_pulses", 32'(n_err), 32'd1);
      chk("t5_done_pulses", 32'(n_done), 32'd1);

      // T6: reset in the middle of a packet
      do_reset();
      send(mkf(`HEAD, 30'h000002A));
      send(mkf(`BODY, 30'h1)); send(mkf(`BODY, 30'h2));
      rstn = 1'b0;
      cyc(1'b0, '0, 1'b0, acc);
      rstn = 1'b1;
      exp_q.delete(); n_err = 0; n_done = 0;
      @(negedge clk);
      chk("t6_valid", 32'(valid_o), 32'd0);
      chk("t6_ready", 32'(ready_o), 32'd1);
      chk("t6_errcnt_rst", 32'(err_cnt_o), 32'd0);
      chk("t6_sid_rst", 32'(src_id_o), 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) send(mkf(`BODY, 30'h20 + 30'(i)));
      send(mkf(`TAIL, 30'h0));
      drain();
      chk("t6_errcnt", 32'(err_cnt_o), 32'd6);
      chk("t6_pktcnt", 32'(pkt_cnt_o), 32'd0);
      chk("t6_err_pulses", 32'(n_err), 32'd6);

      // T7: overlong packet (one error per extra BODY, TAIL still good), then an illegal type
      do_reset();
      send(mkf(`HEAD, 30'h0000055));
      for (int i = 0; i < 7; i++) send(mkf(`BODY, 30'h30 + 30'(i)));
      send(mkf(`TAIL, 30'h0));
      send(mkf(2'b11, 30'h0));
      drain();
      chk("t7_errcnt", 32'(err_cnt_o), 32'd2);
      chk("t7_pktcnt", 32'(pkt_cnt_o), 32'd1);
      chk("t7_done_pulses", 32'(n_done), 32'd1);
      chk("t7_pops", 32'(n_pop), 32'd10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
      $fatal(1);
   end

endmodule
